// File: rtl/load_store_unit_if.sv
// Bus bundle for load_store_unit: CPU request/response plus data-memory port.
// master = CPU datapath and memory (environment side), slave = the load/store unit.
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
   );
   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for a big-endian, word-wide, 1-cycle-latency data memory; sub-word stores use read-modify-write.
// Optional LSU_ERR_EN: reject misaligned, reserved-size and out-of-range requests with resp_err.
module load_store_unit #(
   parameter int MEM_BYTES = 256,
   parameter int ADDR_W    = 32
) (
   input logic              clk,
   input logic              rst_n,
   load_store_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, RESP} state_e;

   state_e            state_q, state_d;
   logic [1:0]        size_q, off_q;
   logic              signed_q, write_q, err_q;
   logic [31:0]       wdata_q, mem_wdata_q, rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              accept, err_d, word_store_d;
   logic [1:0]        size_d, off_d;
   logic              ready_o, rd_o, wr_o, resp_o;

   if ((MEM_BYTES % 4) != 0 || MEM_BYTES < 4) begin : g_bad_mem_bytes
      $error("MEM_BYTES must be a positive multiple of 4");
   end

`ifdef LSU_ERR_EN
   logic [2:0]      nbytes;
   logic [ADDR_W:0] end_addr;
`endif

   assign accept = bus.req_valid && (state_q == IDLE);

   // Size 3 behaves as word; low address bits snap to natural alignment.
   always_comb begin
      size_d = (bus.req_size == 2'd3) ? 2'd2 : bus.req_size;
      off_d  = 2'd0;
      case (size_d)
         2'd0:    off_d = bus.req_addr[1:0];
         2'd1:    off_d = {bus.req_addr[1], 1'b0};
         default: off_d = 2'd0;
      endcase
`ifdef LSU_ERR_EN
      nbytes   = (size_d == 2'd0) ? 3'd1 : (size_d == 2'd1) ? 3'd2 : 3'd4;
      end_addr = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbytes);
      err_d    = (bus.req_size == 2'd3)
              || (bus.req_size == 2'd1 && bus.req_addr[0])
              || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0)
              || (end_addr > (ADDR_W+1)'(MEM_BYTES));
`else
      err_d    = 1'b0;
`endif
      word_store_d = bus.req_write && (size_d == 2'd2);
   end

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sg);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (sz)
         2'd0:    r = {{24{sg & b[7]}}, b};
         2'd1:    r = {{16{sg & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                         input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] r;
      r = w;
      case (sz)
         2'd0: case (off)
            2'd0:    r[31:24] = d[7:0];
            2'd1:    r[23:16] = d[7:0];
            2'd2:    r[15:8]  = d[7:0];
            default: r[7:0]   = d[7:0];
         endcase
         2'd1: if (off[1]) r[15:0] = d[15:0]; else r[31:16] = d[15:0];
         default: r = d;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready_o = 1'b0;
      rd_o    = 1'b0;
      wr_o    = 1'b0;
      resp_o  = 1'b0;
      case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (accept) begin
               if (err_d)             state_d = RESP;
               else if (word_store_d) state_d = WRITE;
               else                   state_d = READ;
            end
         end
         READ:  begin rd_o = 1'b1; state_d = LATCH; end
         LATCH: state_d = write_q ? WRITE : RESP;
         WRITE: begin wr_o = 1'b1; state_d = RESP; end
         RESP:  begin resp_o = 1'b1; state_d = IDLE; end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_q      <= '0;
         off_q       <= '0;
         signed_q    <= 1'b0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         wdata_q     <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
      end else begin
         if (accept) begin
            size_q     <= size_d;
            off_q      <= off_d;
            signed_q   <= bus.req_signed;
            write_q    <= bus.req_write;
            wdata_q    <= bus.req_wdata;
            err_q      <= err_d;
            rdata_q    <= '0;
            mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (word_store_d && !err_d) mem_wdata_q <= bus.req_wdata;
         end
         // mem_rdata is valid here, one cycle after READ pulsed mem_read.
         if (state_q == LATCH) begin
            if (write_q) mem_wdata_q <= merge(bus.mem_rdata, wdata_q, size_q, off_q);
            else         rdata_q     <= extract(bus.mem_rdata, size_q, off_q, signed_q);
         end
      end
   end

   assign bus.req_ready  = ready_o;
   assign bus.mem_read   = rd_o;
   assign bus.mem_write  = wr_o;
   assign bus.resp_valid = resp_o;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural big-endian word memory.
module tb_load_store_unit;
   localparam int ADDR_W    = 32;
   localparam int MEM_BYTES = 256;
`ifdef LSU_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();
   load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct { logic [31:0] rd; bit err; int lat; int acc; } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   int n_vec = 0, n_fail = 0;
   int cyc = 0, last_acc = 0;
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
   logic [ADDR_W-1:0] last_wr_addr = '0;
   logic [31:0]       last_wr_data = '0;

   logic [31:0] marr [0:63] = '{0: 32'h001110AA, default: 32'h0};
   logic [7:0]  ref_mem [0:255] = '{0: 8'h00, 1: 8'h11, 2: 8'h10, 3: 8'hAA, default: 8'h00};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.mem_read)  bus.mem_rdata <= marr[bus.mem_addr[7:2]];
      if (bus.mem_write) marr[bus.mem_addr[7:2]] <= bus.mem_wdata;
   end

   // Response monitor: pops the scoreboard on every resp_valid pulse.
   always @(negedge clk) begin
      if (bus.mem_read) rd_cnt++;
      if (bus.mem_write) begin
         wr_cnt++;
         last_wr_addr = bus.mem_addr;
         last_wr_data = bus.mem_wdata;
      end
      if (bus.mem_read && bus.mem_write) both_cnt++;
      if (bus.resp_valid) begin
         resp_cnt++;
         if (sb.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_resp: got rdata=%h err=%0b, required no response", bus.resp_rdata, bus.resp_err);
         end else begin
            mon_e = sb.pop_front();
            n_vec++;
            if (bus.resp_rdata !== mon_e.rd) begin
               n_fail++; $display("FAIL resp_rdata: got %h, required %h", bus.resp_rdata, mon_e.rd);
            end
            n_vec++;
            if (bus.resp_err !== mon_e.err) begin
               n_fail++; $display("FAIL resp_err: got %0b, required %0b", bus.resp_err, mon_e.err);
            end
            n_vec++;
            if (cyc - mon_e.acc !== mon_e.lat) begin
               n_fail++; $display("FAIL latency: got %0d, required %0d", cyc - mon_e.acc, mon_e.lat);
            end
         end
      end
   end

   function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
      int nb;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      return ERR_EN && ((sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
                        || (64'(a) + 64'(nb) > 64'(MEM_BYTES)));
   endfunction

   function automatic logic [7:0] model_base(input logic [1:0] sz, input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      if (sz == 2'd1) b[0] = 1'b0;
      else if (sz != 2'd0) b[1:0] = 2'b00;
      return b;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg, input logic [31:0] a);
      logic [7:0] b;
      logic [15:0] h;
      b = model_base(sz, a);
      if (model_err(sz, a)) return 32'h0;
      h = {ref_mem[b], ref_mem[b + 8'd1]};
      if (sz == 2'd0) return sg ? {{24{ref_mem[b][7]}}, ref_mem[b]} : {24'h0, ref_mem[b]};
      if (sz == 2'd1) return sg ? {{16{h[15]}}, h} : {16'h0, h};
      return {ref_mem[b], ref_mem[b + 8'd1], ref_mem[b + 8'd2], ref_mem[b + 8'd3]};
   endfunction

   function automatic int model_lat(input bit wr, input logic [1:0] sz, input logic [31:0] a);
      if (model_err(sz, a)) return 1;
      if (wr && sz >= 2'd2) return 2;
      if (wr) return 4;
      return 3;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      logic [7:0] b;
      b = model_base(sz, a);
      if (model_err(sz, a)) return;
      if (sz == 2'd0) ref_mem[b] = wd[7:0];
      else if (sz == 2'd1) begin
         ref_mem[b] = wd[15:8]; ref_mem[b + 8'd1] = wd[7:0];
      end else begin
         ref_mem[b] = wd[31:24]; ref_mem[b + 8'd1] = wd[23:16];
         ref_mem[b + 8'd2] = wd[15:8]; ref_mem[b + 8'd3] = wd[7:0];
      end
   endtask

   task automatic issue(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
      int tries;
      exp_t e;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
      bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
      tries = 0;
      while (!bus.req_ready && tries < 50) begin @(negedge clk); tries++; end
      if (!bus.req_ready) begin
         n_vec++; n_fail++;
         $display("FAIL accept_timeout: req_ready got 0, required 1");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      last_acc = cyc - 1;
      e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat; e.acc = last_acc;
      sb.push_back(e);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 60) begin @(negedge clk); t++; end
      if (sb.size() != 0) begin
         n_vec++; n_fail++;
         $display("FAIL resp_timeout: %0d outstanding, required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
      bus.req_signed = 0; bus.req_addr = '0; bus.req_wdata = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", bus.req_ready); end
      n_vec++; if ({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 4'b0) begin
         n_fail++; $display("FAIL rst_ctrl: got %b, required 0000", {bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write});
      end
      n_vec++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h, required 0", bus.resp_rdata); end
      n_vec++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
         n_fail++; $display("FAIL rst_mem: got addr %h wdata %h, required 0", bus.mem_addr, bus.mem_wdata);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_word_load();
      rd_cnt = 0; wr_cnt = 0;
      issue(0, 2'd2, 0, 32'd0, 32'h0, 32'h001110AA, 0, 3);
      drain();
      n_vec++; if (rd_cnt !== 1 || wr_cnt !== 0) begin
         n_fail++; $display("FAIL wload_pulses: got rd %0d wr %0d, required 1 0", rd_cnt, wr_cnt);
      end
   endtask

   task automatic test_sub_loads();
      issue(0, 2'd0, 1, 32'd3, 32'h0, 32'hFFFFFFAA, 0, 3);
      issue(0, 2'd0, 0, 32'd3, 32'h0, 32'h000000AA, 0, 3);
      issue(0, 2'd1, 1, 32'd0, 32'h0, 32'h00000011, 0, 3);
      issue(0, 2'd1, 1, 32'd2, 32'h0, 32'h000010AA, 0, 3);
      issue(0, 2'd0, 1, 32'd1, 32'h0, 32'h00000011, 0, 3);
      issue(0, 2'd1, 0, 32'd2, 32'h0, 32'h000010AA, 0, 3);
      drain();
   endtask

   task automatic test_err();
      rd_cnt = 0; wr_cnt = 0;
      if (ERR_EN) begin
         issue(0, 2'd1, 1, 32'd1,   32'h0, 32'h0, 1, 1);
         issue(0, 2'd2, 0, 32'd256, 32'h0, 32'h0, 1, 1);
         issue(1, 2'd3, 0, 32'd0,   32'h12345678, 32'h0, 1, 1);
         issue(1, 2'd0, 0, 32'd256, 32'h77, 32'h0, 1, 1);
         drain();
         n_vec++; if (rd_cnt !== 0 || wr_cnt !== 0) begin
            n_fail++; $display("FAIL err_pulses: got rd %0d wr %0d, required 0 0", rd_cnt, wr_cnt);
         end
         issue(0, 2'd0, 0, 32'd255, 32'h0, 32'h0, 0, 3);
         issue(0, 2'd2, 0, 32'd252, 32'h0, 32'h0, 0, 3);
         drain();
      end else begin
         issue(0, 2'd1, 1, 32'd1, 32'h0, 32'h00000011, 0, 3);
         issue(0, 2'd3, 0, 32'd2, 32'h0, 32'h001110AA, 0, 3);
         drain();
         n_vec++; if (rd_cnt !== 2 || wr_cnt !== 0) begin
            n_fail++; $display("FAIL noerr_pulses: got rd %0d wr %0d, required 2 0", rd_cnt, wr_cnt);
         end
      end
   endtask

   task automatic test_mid_reset();
      int t, resp0;
      rd_cnt = 0; wr_cnt = 0; resp0 = resp_cnt;
      issue(1, 2'd1, 0, 32'd2, 32'h00001234, 32'h0, 0, 4);
      void'(sb.pop_back());
      t = 0;
      while (cyc != last_acc + 2 && t < 10) begin @(negedge clk); t++; end
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.req_ready !== 1'b1 || bus.mem_write !== 1'b0) begin
         n_fail++; $display("FAIL midrst_state: got ready %b wr %b, required 1 0", bus.req_ready, bus.mem_write);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      n_vec++; if (wr_cnt !== 0 || resp_cnt !== resp0) begin
         n_fail++; $display("FAIL midrst_abandon: got wr %0d resp %0d, required 0 0", wr_cnt, resp_cnt - resp0);
      end
      issue(0, 2'd2, 0, 32'd0, 32'h0, 32'h001110AA, 0, 3);
      drain();
   endtask

   task automatic test_byte_store();
      rd_cnt = 0; wr_cnt = 0;
      issue(1, 2'd0, 0, 32'd1, 32'h0000005A, 32'h0, 0, 4);
      model_store(2'd0, 32'd1, 32'h5A);
      drain();
      n_vec++; if (rd_cnt !== 1 || wr_cnt !== 1) begin
         n_fail++; $display("FAIL bstore_pulses: got rd %0d wr %0d, required 1 1", rd_cnt, wr_cnt);
      end
      n_vec++; if (last_wr_addr !== 32'h0 || last_wr_data !== 32'h005A10AA) begin
         n_fail++; $display("FAIL bstore_bus: got addr %h data %h, required 0 005a10aa", last_wr_addr, last_wr_data);
      end
      issue(0, 2'd2, 0, 32'd0, 32'h0, 32'h005A10AA, 0, 3);
      drain();
   endtask

   task automatic test_word_store();
      rd_cnt = 0; wr_cnt = 0;
      issue(1, 2'd2, 0, 32'd4, 32'hDEADBEEF, 32'h0, 0, 2);
      model_store(2'd2, 32'd4, 32'hDEADBEEF);
      drain();
      n_vec++; if (rd_cnt !== 0 || wr_cnt !== 1) begin
         n_fail++; $display("FAIL wstore_pulses: got rd %0d wr %0d, required 0 1", rd_cnt, wr_cnt);
      end
      issue(0, 2'd2, 0, 32'd4, 32'h0, 32'hDEADBEEF, 0, 3);
      drain();
   endtask

   task automatic test_back_to_back();
      bit wr, sg;
      logic [1:0] sz;
      logic [31:0] a, wd;
      int prev_acc, prev_lat, lat;
      prev_lat = 0; prev_acc = 0;
      for (int i = 0; i < 16; i++) begin
         wr = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1)); a = 32'($urandom_range(0, 15));
         wd = $urandom;
         lat = model_lat(wr, sz, a);
         issue(wr, sz, sg, a, wd, wr ? 32'h0 : model_load(sz, sg, a), model_err(sz, a), lat);
         if (wr) model_store(sz, a, wd);
         if (i > 0) begin
            n_vec++;
            if (last_acc - prev_acc !== prev_lat + 1) begin
               n_fail++; $display("FAIL b2b_gap: got %0d, required %0d", last_acc - prev_acc, prev_lat + 1);
            end
         end
         prev_acc = last_acc; prev_lat = lat;
      end
      drain();
      for (int w = 0; w < 4; w++) begin
         a = 32'(w * 4);
         issue(0, 2'd2, 0, a, 32'h0, model_load(2'd2, 0, a), 0, 3);
      end
      drain();
      n_vec++; if (both_cnt !== 0) begin
         n_fail++; $display("FAIL rd_wr_overlap: got %0d cycles, required 0", both_cnt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word_load();
      test_sub_loads();
      test_err();
      test_mid_reset();
      test_byte_store();
      test_word_store();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
